// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnI = 1'b0,
    OwnD = 1'b1
  } arb_owner_e;

  // Streak counter must hold MAX_D_STREAK up to 15.
  localparam int unsigned STREAK_W = 4;
  // Timeout counter width; TIMEOUT_CYCLES must fit in this many bits.
  localparam int unsigned TMO_W    = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-fetch, load/store and mem_system signals around the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if;

  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        i_err;

  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic        d_err;

  logic [15:0] m_addr;
  logic [15:0] m_data_in;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_data_out;
  logic        m_done;
  logic        m_stall;
  logic        m_err;

  modport slave (
    input  i_addr, i_rd,
    output i_data_out, i_done, i_stall, i_err,
    input  d_addr, d_data_in, d_rd, d_wr,
    output d_data_out, d_done, d_stall, d_err,
    output m_addr, m_data_in, m_rd, m_wr,
    input  m_data_out, m_done, m_stall, m_err
  );

  modport master (
    output i_addr, i_rd,
    input  i_data_out, i_done, i_stall, i_err,
    output d_addr, d_data_in, d_rd, d_wr,
    input  d_data_out, d_done, d_stall, d_err,
    input  m_addr, m_data_in, m_rd, m_wr,
    output m_data_out, m_done, m_stall, m_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection for the arbiter: D normally wins, but I is forced through
// once D has been granted MAX_D_STREAK times in a row while I was waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_req_i,
  input  logic i_req_d_rd,
  input  logic i_req_d_wr,
  output logic o_grant_i,
  output logic o_grant_d,
  output logic o_d_illegal
);

  logic [STREAK_W-1:0] r_streak;
  logic                w_d_legal;
  logic                w_force_i;

  // A simultaneous load and store is rejected outright, never granted.
  assign w_d_legal   = i_req_d_rd ^ i_req_d_wr;
  assign o_d_illegal = i_idle & i_req_d_rd & i_req_d_wr;
  assign w_force_i   = i_req_i && (r_streak == STREAK_W'(MAX_D_STREAK));
  assign o_grant_i   = i_idle & i_req_i & (w_force_i | ~w_d_legal);
  assign o_grant_d   = i_idle & w_d_legal & ~w_force_i;

  // Count consecutive D grants that starved a waiting I; any gap in I clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (!i_req_i || o_grant_i) begin
      r_streak <= '0;
    end else if (o_grant_d && (r_streak != STREAK_W'(MAX_D_STREAK))) begin
      r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single mem_system port.
// One transaction at a time: IDLE picks and latches, BUSY drives mem_system,
// RESP returns done/err to the owner for one cycle.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_e  r_state;
  arb_owner_e  r_owner;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_m_rd;
  logic        r_m_wr;
  logic        r_i_done;
  logic        r_i_err;
  logic [15:0] r_i_data;
  logic        r_d_done;
  logic        r_d_err;
  logic [15:0] r_d_data;

  logic        w_idle;
  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_d_illegal;
  logic        w_timeout;
  logic        w_d_err;
  logic        w_unused_stall;

  assign w_idle = (r_state == StIdle);

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .i_idle     (w_idle),
    .i_req_i    (bus.i_rd),
    .i_req_d_rd (bus.d_rd),
    .i_req_d_wr (bus.d_wr),
    .o_grant_i  (w_grant_i),
    .o_grant_d  (w_grant_d),
    .o_d_illegal(w_d_illegal)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;

  // BUSY cycle counter, restarted on every grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (w_grant_i || w_grant_d) begin
      r_tmo <= '0;
    end else if (r_state == StBusy) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_timeout = (r_state == StBusy) && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [TMO_W-1:0] w_unused_tmo;
  assign w_unused_tmo = TMO_W'(TIMEOUT_CYCLES);
  assign w_timeout    = 1'b0;
`endif

  // Completion is signalled by m_done only; Stall is informational.
  assign w_unused_stall = bus.m_stall;

  // Arbiter FSM with all mem_system and response outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_owner  <= OwnI;
      r_addr   <= '0;
      r_data   <= '0;
      r_m_rd   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_i_done <= 1'b0;
      r_i_err  <= 1'b0;
      r_i_data <= '0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      r_d_data <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      r_i_done <= 1'b0;
      r_i_err  <= 1'b0;
      r_i_data <= '0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      r_d_data <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_d) begin
            r_state <= StBusy;
            r_owner <= OwnD;
            r_addr  <= bus.d_addr;
            r_data  <= bus.d_data_in;
            r_m_rd  <= bus.d_rd;
            r_m_wr  <= bus.d_wr;
          end else if (w_grant_i) begin
            r_state <= StBusy;
            r_owner <= OwnI;
            r_addr  <= bus.i_addr;
            r_data  <= '0;
            r_m_rd  <= 1'b1;
            r_m_wr  <= 1'b0;
          end
        end
        StBusy: begin
          if (bus.m_err || bus.m_done || w_timeout) begin
            r_state <= StResp;
            r_addr  <= '0;
            r_data  <= '0;
            r_m_rd  <= 1'b0;
            r_m_wr  <= 1'b0;
            // m_err beats m_done; timeout only fires when neither arrived.
            if (bus.m_err || !bus.m_done) begin
              if (r_owner == OwnD) r_d_err <= 1'b1;
              else                 r_i_err <= 1'b1;
            end else if (r_owner == OwnD) begin
              r_d_done <= 1'b1;
              r_d_data <= r_m_rd ? bus.m_data_out : 16'h0000;
            end else begin
              r_i_done <= 1'b1;
              r_i_data <= bus.m_data_out;
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // An illegal D request is refused in the same IDLE cycle it is seen.
  assign w_d_err = r_d_err | w_d_illegal;

  assign bus.m_addr     = r_addr;
  assign bus.m_data_in  = r_data;
  assign bus.m_rd       = r_m_rd;
  assign bus.m_wr       = r_m_wr;

  assign bus.i_done     = r_i_done;
  assign bus.i_err      = r_i_err;
  assign bus.i_data_out = r_i_data;
  assign bus.i_stall    = bus.i_rd & ~r_i_done & ~r_i_err;

  assign bus.d_done     = r_d_done;
  assign bus.d_err      = w_d_err;
  assign bus.d_data_out = r_d_data;
  assign bus.d_stall    = (bus.d_rd | bus.d_wr) & ~r_d_done & ~w_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, a transaction-level reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_mem_arbiter;

  localparam int MaxDStreak = 4;
  localparam int TmoCycles  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_D_STREAK  (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mem_system stand-in: answers after rsp_lat extra BUSY cycles unless hung.
  logic [15:0] rsp_data = 16'h0;
  bit          rsp_err  = 1'b0;
  bit          rsp_hang = 1'b0;
  int          rsp_lat  = 0;
  int          rsp_cnt  = 0;

  always @(posedge clk) begin
    #1;
    bus.m_done     = 1'b0;
    bus.m_err      = 1'b0;
    bus.m_data_out = 16'h0;
    if (bus.m_rd || bus.m_wr) begin
      if (!rsp_hang && rsp_cnt >= rsp_lat) begin
        if (rsp_err) bus.m_err = 1'b1;
        else begin
          bus.m_done     = 1'b1;
          bus.m_data_out = rsp_data;
        end
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
      end
    end else begin
      rsp_cnt = 0;
    end
    bus.m_stall = (bus.m_rd || bus.m_wr) && !bus.m_done;
  end

  // Reference model: one outstanding transaction described by owner/kind/address.
  bit          mdl_on = 1'b0;
  bit          mb     = 1'b0;  // transaction presented to mem_system this cycle
  bit          mr     = 1'b0;  // response cycle
  bit          mr_err = 1'b0;
  bit          m_is_rd;
  int          mown;           // 0 = I, 1 = D
  logic [15:0] maddr, mdata, mrdata;
  int          mcnt;
  int          mstreak = 0;

  always @(negedge clk) begin : model
    logic        e_i_done, e_i_err, e_d_done, e_d_err, e_rd, e_wr;
    logic [15:0] e_i_data, e_d_data;
    bit          d_ok, pick_i, pick_d;
    if (mdl_on) begin
      e_rd     = mb && m_is_rd;
      e_wr     = mb && !m_is_rd;
      e_i_done = mr && mown == 0 && !mr_err;
      e_i_err  = mr && mown == 0 && mr_err;
      e_d_done = mr && mown == 1 && !mr_err;
      e_d_err  = (mr && mown == 1 && mr_err) || (!mb && !mr && bus.d_rd && bus.d_wr);
      e_i_data = e_i_done ? mrdata : 16'h0;
      e_d_data = e_d_done ? mrdata : 16'h0;
      check("mdl_m_rd", bus.m_rd, e_rd);
      check("mdl_m_wr", bus.m_wr, e_wr);
      if (mb) check("mdl_m_addr", bus.m_addr, maddr);
      if (e_wr) check("mdl_m_data_in", bus.m_data_in, mdata);
      check("mdl_i_done", bus.i_done, e_i_done);
      check("mdl_i_err", bus.i_err, e_i_err);
      check("mdl_i_data", bus.i_data_out, e_i_data);
      check("mdl_i_stall", bus.i_stall, bus.i_rd && !e_i_done && !e_i_err);
      check("mdl_d_done", bus.d_done, e_d_done);
      check("mdl_d_err", bus.d_err, e_d_err);
      check("mdl_d_data", bus.d_data_out, e_d_data);
      check("mdl_d_stall", bus.d_stall, (bus.d_rd || bus.d_wr) && !e_d_done && !e_d_err);

      // Advance to the state after the coming clock edge.
      if (!bus.i_rd) mstreak = 0;
      if (!rst) begin
        mb = 0; mr = 0; mstreak = 0;
      end else if (mr) begin
        mr = 0;
      end else if (mb) begin
        mcnt++;
        if (bus.m_err) begin
          mb = 0; mr = 1; mr_err = 1;
        end else if (bus.m_done) begin
          mb = 0; mr = 1; mr_err = 0;
          mrdata = m_is_rd ? bus.m_data_out : 16'h0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (mcnt == TmoCycles) begin
          mb = 0; mr = 1; mr_err = 1;
        end
`endif
      end else begin
        d_ok   = bus.d_rd ^ bus.d_wr;
        pick_i = bus.i_rd && (mstreak == MaxDStreak || !d_ok);
        pick_d = d_ok && !pick_i;
        if (pick_i) begin
          mstreak = 0;
          mb = 1; mown = 0; m_is_rd = 1; maddr = bus.i_addr; mcnt = 0;
        end else if (pick_d) begin
          if (bus.i_rd && mstreak < MaxDStreak) mstreak++;
          mb = 1; mown = 1; m_is_rd = bus.d_rd; maddr = bus.d_addr;
          mdata = bus.d_data_in; mcnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int n_dg, at;
    bit got_i, prev, seen;
    rst = 1'b0;
    bus.i_addr = 16'h0; bus.i_rd = 1'b0;
    bus.d_addr = 16'h0; bus.d_data_in = 16'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    bus.m_data_out = 16'h0; bus.m_done = 1'b0; bus.m_err = 1'b0; bus.m_stall = 1'b0;
    tick();
    mdl_on = 1'b1;
    tick();
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_m_rd", bus.m_rd, 0);
    check("rst_m_wr", bus.m_wr, 0);
    check("rst_m_addr", bus.m_addr, 16'h0);
    check("rst_i_done", bus.i_done, 0);
    check("rst_d_done", bus.d_done, 0);
    check("rst_d_err", bus.d_err, 0);

    // I read hitting in mem_system: done two cycles after the request
    tick();
    bus.i_addr = 16'h0040; bus.i_rd = 1'b1; rsp_data = 16'h1234;
    @(negedge clk);
    check("t1_stall_req", bus.i_stall, 1);
    @(negedge clk);
    check("t1_m_rd", bus.m_rd, 1);
    check("t1_m_addr", bus.m_addr, 16'h0040);
    check("t1_stall_before", bus.i_stall, 1);
    check("t1_no_early_done", bus.i_done, 0);
    @(negedge clk);
    check("t1_done", bus.i_done, 1);
    check("t1_data", bus.i_data_out, 16'h1234);
    check("t1_stall_clear", bus.i_stall, 0);
    tick();
    bus.i_rd = 1'b0;

    // D read with two extra mem_system cycles
    tick();
    bus.d_addr = 16'h0800; bus.d_rd = 1'b1; rsp_data = 16'h0ABC; rsp_lat = 2;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check("t1b_wait_m_rd", bus.m_rd, 1);
      if (k == 3) check("t1b_no_early_done", bus.d_done, 0);
      if (k == 4) check("t1b_done", bus.d_done, 1);
      if (k == 4) check("t1b_data", bus.d_data_out, 16'h0ABC);
    end
    tick();
    bus.d_rd = 1'b0; rsp_lat = 0;

    // I and D store together: store first, then I
    tick();
    bus.i_addr = 16'h0200; bus.i_rd = 1'b1;
    bus.d_addr = 16'h0100; bus.d_data_in = 16'hBEEF; bus.d_wr = 1'b1; rsp_data = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    check("t2_m_wr", bus.m_wr, 1);
    check("t2_m_rd", bus.m_rd, 0);
    check("t2_m_addr", bus.m_addr, 16'h0100);
    check("t2_m_data_in", bus.m_data_in, 16'hBEEF);
    @(negedge clk);
    check("t2_d_done", bus.d_done, 1);
    check("t2_store_data_zero", bus.d_data_out, 16'h0);
    tick();
    bus.d_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_i_granted", bus.m_rd, 1);
    check("t2_i_addr", bus.m_addr, 16'h0200);
    @(negedge clk);
    check("t2_i_done", bus.i_done, 1);
    tick();
    bus.i_rd = 1'b0;

    // Continuous D vs waiting I: four D grants then I
    tick();
    bus.d_addr = 16'h0300; bus.d_rd = 1'b1;
    bus.i_addr = 16'h0400; bus.i_rd = 1'b1; rsp_data = 16'h5555;
    n_dg = 0; got_i = 1'b0; prev = 1'b0;
    for (int c = 0; c < 60 && !got_i; c++) begin
      @(negedge clk);
      if (bus.m_rd && !prev) begin
        if (bus.m_addr == 16'h0300) n_dg++;
        else got_i = 1'b1;
      end
      prev = bus.m_rd;
    end
    check("t3_d_grants", n_dg, 4);
    check("t3_i_granted", got_i, 1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.i_done;
    end
    check("t3_i_done", seen, 1);
    tick();
    bus.i_rd = 1'b0; bus.d_rd = 1'b0;

    // Illegal D request alone
    tick();
    bus.d_addr = 16'h0900; bus.d_rd = 1'b1; bus.d_wr = 1'b1;
    @(negedge clk);
    check("t4_err", bus.d_err, 1);
    check("t4_stall", bus.d_stall, 0);
    tick();
    bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    @(negedge clk);
    check("t4_err_once", bus.d_err, 0);
    check("t4_no_grant", bus.m_rd | bus.m_wr, 0);
    check("t4_no_done", bus.d_done, 0);

    // Illegal D alongside I: I still granted
    tick();
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.i_addr = 16'h0A00; bus.i_rd = 1'b1;
    rsp_data = 16'h2468;
    @(negedge clk);
    check("t4b_err", bus.d_err, 1);
    tick();
    bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    @(negedge clk);
    check("t4b_i_grant", bus.m_rd, 1);
    check("t4b_i_addr", bus.m_addr, 16'h0A00);
    @(negedge clk);
    check("t4b_i_done", bus.i_done, 1);
    check("t4b_i_data", bus.i_data_out, 16'h2468);
    tick();
    bus.i_rd = 1'b0;

    // mem_system error during I read
    tick();
    rsp_err = 1'b1; bus.i_addr = 16'h0500; bus.i_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_m_rd", bus.m_rd, 1);
    @(negedge clk);
    check("t5_i_err", bus.i_err, 1);
    check("t5_no_done", bus.i_done, 0);
    check("t5_stall", bus.i_stall, 0);
    tick();
    bus.i_rd = 1'b0; rsp_err = 1'b0;
    @(negedge clk);
    check("t5_err_once", bus.i_err, 0);
    check("t5_idle", bus.m_rd, 0);

    // Reset in the middle of a hung BUSY
    tick();
    rsp_hang = 1'b1; bus.i_addr = 16'h0600; bus.i_rd = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("t6_still_busy", bus.m_rd, 1);
    tick();
    rst = 1'b0; bus.i_rd = 1'b0;
    @(negedge clk);
    check("t6_pre_reset", bus.m_rd, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_m_rd", bus.m_rd, 0);
    check("t6_no_done", bus.i_done, 0);
    check("t6_no_err", bus.i_err, 0);
    @(negedge clk);
    check("t6_no_done_late", bus.i_done, 0);
    rsp_hang = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Hung mem_system: err after 64 BUSY cycles
    tick();
    rsp_hang = 1'b1; bus.i_addr = 16'h0700; bus.i_rd = 1'b1;
    at = -1;
    for (int k = 0; k < 200 && at < 0; k++) begin
      @(negedge clk);
      if (bus.i_err) at = k;
    end
    check("t7_timeout_at", at, 65);
    check("t7_no_done", bus.i_done, 0);
    tick();
    bus.i_rd = 1'b0; rsp_hang = 1'b0;
`endif

    for (int k = 0; k < 3; k++) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter placed in front of the single mem_system (cache + four_bank_mem) port.
- Shares that port between the instruction-fetch requester (I) and the load/store requester (D).
- Latches one request at a time and drives the mem_system Addr/DataIn/Rd/Wr from registers.
- Routes DataOut/Done/err back to the granted requester only; the other requester sees Stall.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced to win (1..15)
TIMEOUT_CYCLES, 64, BUSY cycles without m_done before timeout error (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-low (0 resets on the next clk edge)
i_addr  in  16  fetch address
i_rd  in  1  fetch read request, held until i_done/i_err
i_data_out  out  16  fetch read data, valid with i_done
i_done  out  1  one-cycle completion pulse to I
i_stall  out  1  i_rd & ~i_done & ~i_err
i_err  out  1  one-cycle error pulse to I
d_addr  in  16  load/store address
d_data_in  in  16  store data
d_rd  in  1  load request, held until done/err
d_wr  in  1  store request, held until done/err
d_data_out  out  16  load data, valid with d_done
d_done  out  1  one-cycle completion pulse to D
d_stall  out  1  (d_rd|d_wr) & ~d_done & ~d_err
d_err  out  1  one-cycle error pulse to D
m_addr  out  16  mem_system Addr
m_data_in  out  16  mem_system DataIn
m_rd  out  1  mem_system Rd
m_wr  out  1  mem_system Wr
m_data_out  in  16  mem_system DataOut
m_done  in  1  mem_system Done
m_stall  in  1  mem_system Stall (informational; completion is m_done)
m_err  in  1  mem_system err

Behaviour:
- Reset (rst=0 at edge): state IDLE, streak=0, owner=I, latched regs=0. All outputs 0 while in IDLE with no request.
- States: IDLE, BUSY, RESP.
- IDLE: m_rd=m_wr=0. If any legal request, pick a winner, latch addr/data/rd/wr/owner, go to BUSY.
- Winner selection:
  - D beats I.
  - Exception: I wins if I is requesting and streak==MAX_D_STREAK.
  - streak increments on each D grant while i_rd=1; clears on any I grant or when i_rd=0. Saturates at MAX_D_STREAK.
- Illegal D (d_rd&d_wr both 1) in IDLE:
  - No grant to D.
  - d_err pulses in that cycle; D takes no grant that cycle.
  - I may still be granted in the same cycle.
- BUSY: m_addr/m_data_in/m_rd/m_wr driven from latched regs. Request inputs are ignored (changes mid-op have no effect).
  - m_done=1: capture m_data_out, go to RESP.
  - m_err=1 (priority over m_done): owner's err pulses next cycle (in RESP, done=0), then IDLE.
- RESP (1 cycle):
  - m_rd=m_wr=0.
  - Owner's done=1; owner's data_out=captured value (0 for stores).
  - Then go to IDLE.
- Latency: request seen in IDLE cycle N → BUSY from N+1. A mem_system hit (m_done in first BUSY cycle) gives done at N+2.
- Back-to-back throughput: new grant earliest the cycle after RESP.
- Non-owner done/err are always 0. data_out is 0 when done=0.
- Reset mid-op: the in-flight transaction is abandoned. m_rd/m_wr are 0 from the cycle after the reset edge, and no done is issued.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without m_done/m_err: go to RESP with the owner's err=1 (done=0), then IDLE.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants (IDLE, BUSY, RESP)
  - owner constants (OWN_I=0, OWN_D=1)
  - streak and timeout counter widths
- Sub-module mem_arb_pick: combinational winner selection plus streak counter register.

Test Plan:
- Reset, then i_rd=1, i_addr=16'h0040; mem_system hit returns 16'h1234 → i_done=1 with i_data_out=16'h1234 exactly 2 cycles later; i_stall=1 the cycle before.
- i_rd and d_wr (d_addr=16'h0100, d_data_in=16'hBEEF) asserted in the same cycle → m_wr=1 first with m_addr=16'h0100; after d_done, I is granted.
- d_rd held continuously, i_rd held → exactly 4 D grants, then I granted; streak returns to 0.
- d_rd=d_wr=1 in IDLE → d_err pulses for 1 cycle; m_rd=m_wr=0; no d_done.
- m_err=1 during an I read → i_err pulses once; i_done stays 0; arbiter returns to IDLE.
- With MEM_ARB_TIMEOUT_EN and m_done tied 0 → err to the owner after 64 BUSY cycles. Separately, rst=0 mid-BUSY → m_rd=0 next cycle and no done.
